// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the I/D unified-RAM port arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      PORT_NONE = 2'd0,
      PORT_I    = 2'd1,
      PORT_D    = 2'd2
   } port_e;

   // Read-return tag layout: {is_i, is_d_load}
   localparam int unsigned TAG_D_LOAD = 0;
   localparam int unsigned TAG_IS_I   = 1;
   localparam int unsigned TAG_W      = 2;

   localparam int unsigned WAIT_W = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch, data, RAM and status signals around the port arbiter.
interface mem_port_arbiter_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned CNT_W  = 32
);
   logic              i_req;
   logic [ADDR_W-1:0] i_addr;
   logic              i_gnt;
   logic              i_rvalid;
   logic [DATA_W-1:0] i_rdata;

   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic              d_gnt;
   logic              d_rvalid;
   logic [DATA_W-1:0] d_rdata;

   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   logic              stall_if;
   logic              stall_mem;
   logic [CNT_W-1:0]  conflict_cnt;

   // Arbiter side
   modport slave (
      input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
      output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
      output mem_en, mem_we, mem_addr, mem_wdata,
      output stall_if, stall_mem, conflict_cnt
   );

   // Pipeline + RAM side
   modport master (
      output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
      input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
      input  mem_en, mem_we, mem_addr, mem_wdata,
      input  stall_if, stall_mem, conflict_cnt
   );

endinterface

// File: rtl/mem_port_arbiter_sat_counter.sv
// Up-counter with synchronous active-low clear that sticks at all-ones.
module sat_counter #(
   parameter int unsigned W = 32
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         inc_i,
   output logic [W-1:0] cnt_o
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (inc_i && (cnt_q != '1)) cnt_d = cnt_q + W'(1);
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) cnt_q <= '0;
      else         cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the fetch and data stages onto one single-port RAM, routes the
// 1-cycle read return to the winner and raises per-stage stalls.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W   = 32,
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned MAX_WAIT = 3,
   parameter int unsigned CNT_W    = 32
) (
   input  logic                clock,
   input  logic                reset,
   mem_port_arbiter_if.slave   bus
);

   localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);

   port_e              winner;
   logic [WAIT_W-1:0]  wait_q, wait_d;
   logic [TAG_W-1:0]   tag_q, tag_d;
   logic [ADDR_W-1:0]  addr_mux;
   logic [DATA_W-1:0]  wdata_mux;
   logic               en_mux, we_mux;

   // Grants are suppressed while reset is held so nothing reaches the RAM.
   always_comb begin
      winner = PORT_NONE;
      if (reset) begin
         if (bus.i_req && bus.d_req) winner = (wait_q == MAX_WAIT_C) ? PORT_I : PORT_D;
         else if (bus.i_req)         winner = PORT_I;
         else if (bus.d_req)         winner = PORT_D;
      end
   end

   always_comb begin
      addr_mux  = '0;
      wdata_mux = '0;
      en_mux    = 1'b0;
      we_mux    = 1'b0;
      unique case (winner)
         PORT_I: begin
            addr_mux = bus.i_addr;
            en_mux   = 1'b1;
         end
         PORT_D: begin
            addr_mux  = bus.d_addr;
            wdata_mux = bus.d_wdata;
            we_mux    = bus.d_we;
            en_mux    = 1'b1;
         end
         default: ;
      endcase
   end

   always_comb begin
      wait_d = wait_q;
      if ((winner == PORT_I) || !bus.i_req)       wait_d = '0;
      else if (bus.d_req && (winner == PORT_D))   wait_d = wait_q + WAIT_W'(1);

      tag_d             = '0;
      tag_d[TAG_IS_I]   = (winner == PORT_I);
      tag_d[TAG_D_LOAD] = (winner == PORT_D) && !bus.d_we;
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         wait_q <= '0;
         tag_q  <= '0;
      end else begin
         wait_q <= wait_d;
         tag_q  <= tag_d;
      end
   end

   assign bus.i_gnt     = (winner == PORT_I);
   assign bus.d_gnt     = (winner == PORT_D);
   assign bus.mem_en    = en_mux;
   assign bus.mem_we    = we_mux;
   assign bus.mem_addr  = addr_mux;
   assign bus.mem_wdata = wdata_mux;

   assign bus.stall_if  = reset & bus.i_req & ~bus.i_gnt;
   assign bus.stall_mem = reset & bus.d_req & ~bus.d_gnt;

   assign bus.i_rvalid = tag_q[TAG_IS_I];
   assign bus.d_rvalid = tag_q[TAG_D_LOAD];
   assign bus.i_rdata  = tag_q[TAG_IS_I]   ? bus.mem_rdata : '0;
   assign bus.d_rdata  = tag_q[TAG_D_LOAD] ? bus.mem_rdata : '0;

   sat_counter #(.W(CNT_W)) u_conflict_cnt (
      .clk_i  (clock),
      .rst_ni (reset),
      .inc_i  (bus.i_req & bus.d_req),
      .cnt_o  (bus.conflict_cnt)
   );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed scenarios then random traffic.
module tb_mem_port_arbiter;

   localparam int unsigned MAX_WAIT = 3;
   localparam int unsigned CNT_W    = 4;

   logic clk;
   logic rst_n;

   mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32), .CNT_W(CNT_W)) bus ();

   mem_port_arbiter #(
      .ADDR_W   (32),
      .DATA_W   (32),
      .MAX_WAIT (MAX_WAIT),
      .CNT_W    (CNT_W)
   ) dut (
      .clock (clk),
      .reset (rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic             i_gnt, d_gnt, mem_en, mem_we, stall_if, stall_mem, i_rvalid, d_rvalid;
      logic [31:0]      mem_addr, mem_wdata, i_rdata, d_rdata;
      logic [CNT_W-1:0] cnt;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;

   // Reference state: consecutive I losses, saturating conflict total, pending read owner
   int   m_loss = 0;
   int   m_cnt  = 0;
   bit   m_pi   = 0;
   bit   m_pd   = 0;

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endfunction

   // One clock of stimulus; pushes this cycle's expected outputs, then advances the model.
   task automatic cycle(input bit rst, input bit ir, input logic [31:0] ia,
                        input bit dr, input bit dw, input logic [31:0] da,
                        input logic [31:0] dd, input logic [31:0] rd);
      exp_t e;
      int   win;
      @(posedge clk); #1;
      rst_n         = rst;
      bus.i_req     = ir;
      bus.i_addr    = ia;
      bus.d_req     = dr;
      bus.d_we      = dw;
      bus.d_addr    = da;
      bus.d_wdata   = dd;
      bus.mem_rdata = rd;

      win = 0;
      if (rst) begin
         if (ir && dr)  win = (m_loss >= int'(MAX_WAIT)) ? 1 : 2;
         else if (ir)   win = 1;
         else if (dr)   win = 2;
      end
      e.i_gnt     = (win == 1);
      e.d_gnt     = (win == 2);
      e.mem_en    = (win != 0);
      e.mem_we    = (win == 2) && dw;
      e.mem_addr  = (win == 1) ? ia : (win == 2) ? da : 32'h0;
      e.mem_wdata = (win == 2) ? dd : 32'h0;
      e.stall_if  = rst && ir && (win != 1);
      e.stall_mem = rst && dr && (win != 2);
      e.i_rvalid  = m_pi;
      e.d_rvalid  = m_pd;
      e.i_rdata   = m_pi ? rd : 32'h0;
      e.d_rdata   = m_pd ? rd : 32'h0;
      e.cnt       = CNT_W'(m_cnt);
      sb_q.push_back(e);

      if (!rst) begin
         m_loss = 0; m_cnt = 0; m_pi = 0; m_pd = 0;
      end else begin
         m_pi = (win == 1);
         m_pd = (win == 2) && !dw;
         if (ir && dr && (m_cnt < (1 << CNT_W) - 1)) m_cnt++;
         if (!ir || win == 1) m_loss = 0;
         else if (win == 2)   m_loss++;
      end
   endtask

   task automatic idle(input bit rst, input logic [31:0] rd);
      cycle(rst, 0, 32'h0, 0, 0, 32'h0, 32'h0, rd);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("i_gnt",        32'(bus.i_gnt),        32'(e.i_gnt));
            chk("d_gnt",        32'(bus.d_gnt),        32'(e.d_gnt));
            chk("mem_en",       32'(bus.mem_en),       32'(e.mem_en));
            chk("mem_we",       32'(bus.mem_we),       32'(e.mem_we));
            chk("mem_addr",     bus.mem_addr,          e.mem_addr);
            chk("mem_wdata",    bus.mem_wdata,         e.mem_wdata);
            chk("stall_if",     32'(bus.stall_if),     32'(e.stall_if));
            chk("stall_mem",    32'(bus.stall_mem),    32'(e.stall_mem));
            chk("i_rvalid",     32'(bus.i_rvalid),     32'(e.i_rvalid));
            chk("d_rvalid",     32'(bus.d_rvalid),     32'(e.d_rvalid));
            chk("i_rdata",      bus.i_rdata,           e.i_rdata);
            chk("d_rdata",      bus.d_rdata,           e.d_rdata);
            chk("conflict_cnt", 32'(bus.conflict_cnt), 32'(e.cnt));
         end
      end
   end

   initial begin : stimulus
      int waited;
      rst_n = 0;
      bus.i_req = 0; bus.i_addr = '0; bus.d_req = 0; bus.d_we = 0;
      bus.d_addr = '0; bus.d_wdata = '0; bus.mem_rdata = '0;

      // Reset held with both ports requesting
      repeat (2) cycle(0, 1, 32'h00400000, 1, 0, 32'h10010000, 32'h0, 32'h12345678);

      // Lone fetch and its return
      cycle(1, 1, 32'h00400000, 0, 0, 32'h0, 32'h0, 32'h00500093);
      idle(1, 32'h00500093);

      // Store: no read return
      cycle(1, 0, 32'h0, 1, 1, 32'h10010000, 32'hDEADBEEF, 32'hAAAA5555);
      idle(1, 32'hAAAA5555);

      // Eight conflict cycles from a clean reset: D,D,D,I,D,D,D,I
      idle(0, 32'h0);
      for (int i = 0; i < 8; i++)
         cycle(1, 1, 32'h00400000 + 32'(4*i), 1, 0, 32'h10010000 + 32'(4*i), 32'h0, $urandom);
      idle(1, 32'h0BADF00D);

      // Load granted, reset on the return cycle, nothing afterwards
      cycle(1, 0, 32'h0, 1, 0, 32'h10010040, 32'h0, 32'h11111111);
      idle(0, 32'h22222222);
      idle(1, 32'h33333333);
      idle(1, 32'h44444444);

      // Counter saturation
      for (int i = 0; i < 20; i++)
         cycle(1, 1, $urandom, 1, $urandom_range(0, 1) == 1, $urandom, $urandom, $urandom);
      idle(1, 32'h0);

      // Random traffic with occasional resets
      for (int i = 0; i < 400; i++)
         cycle($urandom_range(0, 31) != 0, $urandom_range(0, 3) != 0, $urandom,
               $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom,
               $urandom, $urandom);
      idle(1, 32'h0);
      idle(1, 32'h0);

      waited = 0;
      while (sb_q.size() > 0 && waited < 10) begin
         @(negedge clk);
         waited++;
      end
      @(posedge clk);
      if (sb_q.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous unified RAM between the instruction-fetch stage (I port) and the data-memory stage (D port) of the RV32 pipeline.
- Grants at most one access per cycle and forwards the winner's command to the RAM.
- Tags the 1-cycle-latency read return back to the correct requester.
- Drives per-stage stall signals to the pipeline register control, and keeps a starvation guard plus a conflict performance counter.

Parameters:
- ADDR_W, 32, address width of both ports and the RAM.
- DATA_W, 32, data width.
- MAX_WAIT, 3, consecutive I-port losses tolerated before the I port is forced to win (legal range 1..15).
- CNT_W, 32, width of the conflict performance counter.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset, sampled on the rising edge of clock).
- i_req  in  1  fetch request (read only).
- i_addr  in  ADDR_W  fetch address.
- i_gnt  out  1  fetch granted this cycle.
- i_rvalid  out  1  i_rdata valid (cycle after the grant).
- i_rdata  out  DATA_W  fetched word.
- d_req  in  1  data request.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_gnt  out  1  data granted this cycle.
- d_rvalid  out  1  d_rdata valid (cycle after a granted load).
- d_rdata  out  DATA_W  loaded word.
- mem_en  out  1  RAM access enable.
- mem_we  out  1  RAM write enable.
- mem_addr  out  ADDR_W  RAM address.
- mem_wdata  out  DATA_W  RAM write data.
- mem_rdata  in  DATA_W  RAM read data, valid one cycle after mem_en with mem_we=0.
- stall_if  out  1  i_req & ~i_gnt.
- stall_mem  out  1  d_req & ~d_gnt.
- conflict_cnt  out  CNT_W  number of cycles with i_req & d_req, saturating.

Behaviour:

Arbitration (combinational on the current inputs and state):
- Only one requester: that requester wins.
- Both requesting:
  - D wins when wait_cnt < MAX_WAIT.
  - I wins when wait_cnt == MAX_WAIT.
- Neither requesting: no grant, mem_en = 0.
- mem_en, mem_we, mem_addr and mem_wdata are muxed from the winner.
  - mem_we = d_we only when D wins; otherwise 0.
  - When there is no grant, mem_addr and mem_wdata hold 0.
- At most one of i_gnt / d_gnt is 1 in any cycle.

Starvation counter wait_cnt (width 4):
- Increments when both request and D wins.
- Clears to 0 whenever I wins, or when i_req = 0.
- Holds otherwise.
- Never exceeds MAX_WAIT.

Read return:
- A 2-bit registered tag {is_i, is_d_load} is captured at each edge from the current grant.
- Next cycle:
  - i_rvalid = tag.is_i.
  - d_rvalid = tag.is_d_load; a store never raises d_rvalid.
- Latency is exactly 1 cycle from grant to rvalid.
- i_rdata and d_rdata are both driven from mem_rdata when their rvalid is 1, otherwise 0.

conflict_cnt:
- Increments by 1 on each cycle with i_req & d_req.
- Saturates at all-ones and does not wrap.

Reset (reset == 0 at a rising edge):
- wait_cnt = 0, tag = 0, conflict_cnt = 0.
- Therefore i_rvalid = 0, d_rvalid = 0, i_rdata = 0, d_rdata = 0 in the following cycle.
- While reset is low, grants are forced to 0, so mem_en = 0, stall_if = 0 and stall_mem = 0.
- A read issued the cycle before reset asserts is dropped; no rvalid is produced after reset.

Boundary conditions:
- A request held across a loss keeps its address stable (the requester's obligation); the arbiter does not latch it.
- Back-to-back grants to the same port are allowed every cycle.
- MAX_WAIT losses followed by a win give the I port a worst-case wait of MAX_WAIT cycles.

Decomposition:
- Package mem_arb_pkg holds:
  - localparams PORT_NONE = 2'd0, PORT_I = 2'd1, PORT_D = 2'd2 (winner encoding);
  - the tag bit positions;
  - the WAIT_W = 4 constant.
- One natural sub-module: sat_counter (parameterised width, inc, synchronous active-low clear, saturates at all-ones). It is used for conflict_cnt.
- wait_cnt stays inline because of its MAX_WAIT cap logic.

Test Plan:
- Reset low 2 cycles with i_req = d_req = 1 → all grants, rvalids and conflict_cnt are 0; mem_en = 0.
- Only i_req = 1, i_addr = 0x00400000, mem_rdata = 0x00500093 → i_gnt = 1 and mem_addr = 0x00400000 in the same cycle; next cycle i_rvalid = 1 and i_rdata = 0x00500093.
- Store d_req = 1, d_we = 1, d_addr = 0x10010000, d_wdata = 0xDEADBEEF → mem_we = 1, mem_wdata = 0xDEADBEEF; next cycle d_rvalid = 0.
- Both requesting continuously for 8 cycles with MAX_WAIT = 3 → grant pattern D,D,D,I,D,D,D,I; stall_if = 1 on D cycles; conflict_cnt = 8.
- Load granted to D, then reset low in the next cycle → d_rvalid = 0 after reset; no stale data appears.
- CNT_W = 4 with 20 conflict cycles → conflict_cnt stops at 15.
